// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb over one shared memory port.
// Optional perf counters (instr_count, stall_count) enabled by defining INSTR_SEQ_PERF_EN.
module instr_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic [4:0] ir_opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       reg_we,
  output logic       nz_we,
  output logic       retired,
  output logic       fault,
  output logic [2:0] state
`ifdef INSTR_SEQ_PERF_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_e;

  localparam bit             TO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               op_nz, op_jmp, op_ld, op_st, op_wr, timeout_c;

  // Opcode classes driving the per-state strobes
  always_comb begin
    op_ld  = (ir_opcode == 5'b00100);
    op_st  = (ir_opcode == 5'b00101);
    op_jmp = ir_opcode[3];
    op_nz  = 1'b0;
    op_wr  = 1'b0;
    case (ir_opcode)
      5'b00001, 5'b00010, 5'b00011,
      5'b10001, 5'b10010, 5'b10011: op_nz = 1'b1;
      default:                      op_nz = 1'b0;
    endcase
    case (ir_opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b10000,
      5'b10001, 5'b10010, 5'b10110, 5'b01100, 5'b11100: op_wr = 1'b1;
      default:                                          op_wr = 1'b0;
    endcase
  end

  // The cycle that would be wait number MEM_TIMEOUT; an ack in the same cycle wins
  assign timeout_c = TO_EN && !mem_ready && (wait_cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_sel = 1'b0;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    reg_we  = 1'b0;
    nz_we   = 1'b0;
    retired = 1'b0;
    fault   = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        nz_we   = op_nz;
        pc_load = op_jmp;
        state_d = (op_ld || op_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = op_st;
        if (mem_ready)      state_d = S_WB;
        else if (timeout_c) state_d = S_FAULT;
      end
      S_WB: begin
        retired = 1'b1;
        reg_we  = op_wr;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter restarts on any state change and on every acknowledge
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d != state_q) || (mem_req && mem_ready)) wait_cnt_d = '0;
    else if (mem_req)                                   wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  assign state = state_q;

`ifdef INSTR_SEQ_PERF_EN
  logic [31:0] instr_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retired)                instr_cnt_q <= instr_cnt_q + 32'd1;
      if (mem_req && !mem_ready)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign instr_count = instr_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control FSM for the 16-bit processor. It sequences each instruction through fetch, decode, execute, optional memory access and write-back over a single shared memory port. It drives the one-cycle strobes for the IR, PC, register file and NZ flags, and the memory handshake. It sits beside the combinational opcode decoder, which supplies mux selects; this block supplies timing.

Parameters:
MEM_TIMEOUT, 255, max wait cycles with mem_req high and mem_ready low before FAULT; 0 disables the timeout
CNT_W, 8, width of the internal wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  1 = start/continue issuing instructions
ir_opcode  in  5  opcode field of the IR; valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request; held until mem_ready
mem_we  out  1  1 = write (st data phase only)
mem_sel  out  1  0 = instruction fetch address (PC), 1 = data address
ir_load  out  1  load IR from memory read data
pc_inc  out  1  PC <= PC+2
pc_load  out  1  PC <= branch/jump target (datapath resolves the condition)
reg_we  out  1  register file write enable
nz_we  out  1  update NZ flags
retired  out  1  one-cycle pulse per completed instruction
fault  out  1  sticky memory-timeout indicator
state  out  3  current state encoding, for debug

Behaviour:
- Reset: asynchronous and active-low. On assertion the FSM goes to IDLE immediately and all outputs are 0. Reset mid-access drops mem_req in the same cycle. The wait counter clears.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. Outputs are decoded from state plus inputs, with no extra register stage.
- IDLE: all strobes 0. Moves to FETCH when run=1.
- FETCH: mem_req=1, mem_sel=0, mem_we=0.
  - In the cycle mem_ready=1: ir_load=1 and pc_inc=1, then move to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: one cycle, no strobes. Moves to EXEC.
- EXEC: one cycle.
  - nz_we=1 for add 00001, sub 00010, cmp 00011, addi 10001, subi 10010, cmpi 10011.
  - pc_load=1 for jump class, where opcode[3]=1 (01xxx, 11xxx).
  - Next state is MEM for ld 00100 or st 00101; otherwise WB.
- MEM: mem_req=1, mem_sel=1; mem_we=1 only for st.
  - On mem_ready=1, move to WB; otherwise count wait cycles.
- WB: one cycle, retired=1.
  - reg_we=1 for mv 00000, add, sub, ld, mvi 10000, addi, subi, mvhi 10110, callr 01100, call 11100.
  - Next state is FETCH if run=1, else IDLE.
- Unlisted opcodes: executed as NOP, with no strobes except retired.
- Handshake: mem_req, mem_sel and mem_we are stable while mem_req=1 and not yet acknowledged. mem_ready is ignored when mem_req=0.
- Wait counter: clears on every state entry and on every acknowledge.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT.
  - mem_ready=1 in that same cycle wins, so no fault is raised.
- FAULT: fault=1 and all other strobes 0. Exit only through reset_n.
- run is sampled only in IDLE and WB. Dropping run mid-instruction completes that instruction first.
- Latency with zero-wait memory: 4 cycles FETCH→WB for non-memory instructions, 5 for ld/st. Each memory wait cycle adds one.

Optional Feature:
Macro: INSTR_SEQ_PERF_EN
- With it defined, two extra outputs are added:
  - instr_count[31:0]: increments on retired, wraps at 2^32.
  - stall_count[31:0]: increments each cycle mem_req=1 and mem_ready=0.
  - Both clear on reset.
- Without it, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Zero-wait add: run=1, ir_opcode=00001, mem_ready=1. Expect state 1,2,3,5,1. nz_we in EXEC, reg_we and retired in WB. ir_load and pc_inc are in FETCH only.
- ld with 3 data wait cycles: expect mem_req=1 and mem_sel=1 for 4 cycles, mem_we=0. WB follows the ack, with reg_we=1. Total 8 cycles FETCH→WB.
- st with zero wait: expect mem_we=1 only in MEM, and reg_we=0 in WB.
- Jump 11000: expect pc_load=1 for exactly one cycle in EXEC, no MEM state, reg_we=0.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 in FETCH. Expect FAULT after 4 wait cycles, fault=1 and mem_req=0, held until reset_n=0. Repeat with mem_ready=1 on the 4th cycle: expect no fault.
- reset_n pulsed low mid-MEM: expect mem_req=0 and state=0 without waiting for a clock edge. Drop run during EXEC: expect the instruction to retire, then IDLE.
